mont_mult_core: RTL

//  Bit-serial radix-2 Montgomery multiplier: P_out = A*B*2^-K mod m.

---
 rtl/mont_pkg.sv | 17 +
 rtl/mont_mult_core_if.sv | 12 +
 rtl/mont_step.sv | 18 +
 rtl/mont_mult_core.sv | 77 +++++++
 4 files changed

// File: rtl/mont_pkg.sv
// Shared definitions for the bit-serial radix-2 Montgomery multiplier.
package mont_pkg;
  localparam int unsigned K_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOP   = 2'd1,
    REDUCE = 2'd2
  } state_t;

  // Iteration counter width; clamped to one bit so that K=1 still has a counter.
  function automatic int unsigned cnt_width(input int unsigned k);
    return (k > 1) ? $clog2(k) : 1;
  endfunction

  localparam int unsigned CNT_W_DEFAULT = cnt_width(K_DEFAULT);
endpackage

// File: rtl/mont_mult_core_if.sv
// Start/done handshake between the modular-multiply sequencer and the Montgomery core.
interface mont_mult_core_if #(parameter int unsigned K = mont_pkg::K_DEFAULT);
  logic         start;
  logic [K-1:0] A;
  logic [K-1:0] B;
  logic [K-1:0] m;
  logic [K-1:0] P_out;
  logic         done;

  modport master (output start, A, B, m, input  P_out, done);
  modport slave  (input  start, A, B, m, output P_out, done);
endinterface

// File: rtl/mont_step.sv
// One radix-2 Montgomery iteration: add the selected multiplicand, make even, halve.
module mont_step #(
  parameter int unsigned K = mont_pkg::K_DEFAULT
) (
  input  logic [K+1:0] acc,
  input  logic [K-1:0] br,
  input  logic [K-1:0] mr,
  input  logic         a_bit,
  output logic [K+1:0] acc_next
);
  logic [K+1:0] t;

  always_comb begin
    t = acc + (a_bit ? {2'b00, br} : '0);
    if (t[0]) t = t + {2'b00, mr};
    acc_next = {1'b0, t[K+1:1]};
  end
endmodule

// File: rtl/mont_mult_core.sv
// Bit-serial Montgomery multiplier core: P_out = A*B*2^-K mod m, K+2 cycles per result.
module mont_mult_core
  import mont_pkg::*;
#(
  parameter int unsigned K = K_DEFAULT
) (
  input logic            clk,
  input logic            rst,
  mont_mult_core_if.slave bus
);
  localparam int unsigned CW = cnt_width(K);

  state_t        state;
  logic [K-1:0]  ar;
  logic [K-1:0]  br;
  logic [K-1:0]  mr;
  logic [K+1:0]  acc;
  logic [CW-1:0] cnt;
  logic [K+1:0]  acc_next;
  logic [K-1:0]  reduced;
  logic [K-1:0]  p_reg;
  logic          done_reg;

  mont_step #(.K(K)) u_step (
    .acc      (acc),
    .br       (br),
    .mr       (mr),
    .a_bit    (ar[cnt]),
    .acc_next (acc_next)
  );

  // acc < 2*mr after the loop, so a single conditional subtraction suffices.
  always_comb begin
    reduced = K'((acc >= {2'b00, mr}) ? acc - {2'b00, mr} : acc);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ar       <= '0;
      br       <= '0;
      mr       <= '0;
      acc      <= '0;
      cnt      <= '0;
      p_reg    <= '0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            ar    <= bus.A;
            br    <= bus.B;
            mr    <= bus.m;
            acc   <= '0;
            cnt   <= '0;
            state <= LOOP;
          end
        end
        LOOP: begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(K - 1)) state <= REDUCE;
        end
        REDUCE: begin
          p_reg    <= reduced;
          done_reg <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.P_out = p_reg;
  assign bus.done  = done_reg;
endmodule
